// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long/repeat strobes.
// Auto-repeat in the LONG state is compiled only with BTN_AUTO_REPEAT_EN.
module button_event #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held,
    output logic long_held
);

    // Real arithmetic keeps CLK_FREQ*MS from overflowing 32 bits
    localparam real LONG_R    = real'(CLK_FREQ) * real'(LONG_MS) / 1000.0;
    localparam int  LONG_RAW  = int'(LONG_R);
    localparam int  LONG_CYC  = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int  HW        = $clog2(LONG_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam real REP_R      = real'(CLK_FREQ) * real'(REPEAT_MS) / 1000.0;
    localparam int  REP_RAW    = int'(REP_R);
    localparam int  REPEAT_CYC = (REP_RAW < 1) ? 1 : REP_RAW;
    localparam int  RW         = $clog2(REPEAT_CYC + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prev;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_nxt;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;
    logic            w_rise;
    logic            w_fall;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RW-1:0]   r_rep_cnt;
    logic [RW-1:0]   w_rep_nxt;
    logic            r_repeat;
    logic            w_repeat_nxt;
`endif

    assign w_rise = btn_level & ~r_prev;
    assign w_fall = ~btn_level & r_prev;

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        w_rep_nxt     = r_rep_cnt;
        w_repeat_nxt  = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = '0;
                    w_press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // A fall outranks the long threshold on the same edge
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    w_rep_nxt     = '0;
`endif
                end else if (btn_level) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = LONG;
                        w_long_nxt  = 1'b1;
                        w_hold_nxt  = '0;
`ifdef BTN_AUTO_REPEAT_EN
                        w_rep_nxt   = '0;
`endif
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            LONG: begin
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_hold_nxt    = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    w_rep_nxt     = '0;
                end else if (btn_level) begin
                    if (r_rep_cnt == REP_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Reset captures the live level so a held button never looks like a rise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_prev     <= btn_level;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep_cnt  <= '0;
            r_repeat   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= btn_level;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
`ifdef BTN_AUTO_REPEAT_EN
            r_rep_cnt  <= w_rep_nxt;
            r_repeat   <= w_repeat_nxt;
`endif
        end
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign held          = (r_state != IDLE);
    assign long_held     = (r_state == LONG);
`ifdef BTN_AUTO_REPEAT_EN
    assign repeat_pulse  = r_repeat;
`else
    assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced, level-valued button signal from the debounce stage into single-cycle event strobes for downstream control logic: press, release, long-press, and optional auto-repeat while held. It sits directly after the debounce stage. It assumes its input is already synchronous and bounce-free.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- LONG_MS, 1000: hold time in ms before the long-press event fires.
- REPEAT_MS, 200: interval in ms between auto-repeat strobes after a long press.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_level  in  1  debounced button level from the debounce stage; 1 = pressed.
- press_pulse  out  1  one-cycle strobe on a press.
- release_pulse  out  1  one-cycle strobe on a release.
- long_pulse  out  1  one-cycle strobe when the hold reaches LONG_MS.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_MS after long_pulse while still held.
- held  out  1  level; high while the state is not IDLE.
- long_held  out  1  level; high while the state is LONG.

## Operation
- Cycle constants are computed in real arithmetic to avoid 32-bit overflow, then cast to int:
  - LONG_CYC = CLK_FREQ*LONG_MS/1000
  - REPEAT_CYC = CLK_FREQ*REPEAT_MS/1000
  - Each constant is clamped to a minimum of 1.
- Counter widths:
  - hold_cnt is $clog2(LONG_CYC+1) bits.
  - rep_cnt is $clog2(REPEAT_CYC+1) bits.
  - Neither counter ever wraps; each is cleared before it reaches its terminal value plus 1.
- prev register: holds btn_level from the previous cycle.
  - rise = btn_level & ~prev
  - fall = ~btn_level & prev
- The FSM has 3 states: IDLE, PRESSED, LONG.
  - IDLE, on rise: go to PRESSED; hold_cnt<=0; press_pulse<=1.
  - PRESSED, btn_level high and hold_cnt==LONG_CYC-1: go to LONG; long_pulse<=1; rep_cnt<=0.
  - PRESSED, btn_level high otherwise: hold_cnt++.
  - PRESSED or LONG, on fall: go to IDLE; release_pulse<=1; both counters cleared.
  - LONG, btn_level high: rep_cnt++. When rep_cnt==REPEAT_CYC-1: repeat_pulse<=1 and rep_cnt<=0.
- Priority: fall beats the long and repeat thresholds in the same cycle. A release therefore never emits long_pulse or repeat_pulse in the same or the next cycle.
- All strobes are registered and high for exactly one cycle. At most one strobe is high in any cycle.
- Reset behaviour:
  - All outputs go to 0, the state goes to IDLE, and the counters go to 0.
  - prev<=btn_level, so a button already held through reset produces no press_pulse.
  - That held button produces no release_pulse when it is later released, because the state is IDLE.
  - A reset mid-hold aborts silently; no release_pulse is emitted.

## Timing
- Let E0 be the first rising clk edge that samples btn_level=1 after it was 0.
- press_pulse is high during the cycle after E0.
- long_pulse is high during the cycle after E0+LONG_CYC, i.e. exactly LONG_CYC cycles after press_pulse.
- The first repeat_pulse comes REPEAT_CYC cycles after long_pulse; later ones follow every REPEAT_CYC cycles.
- release_pulse is high during the cycle after the first edge that samples btn_level=0. held falls in that same cycle.
- Latency from input to output is 1 cycle for every event. There is no combinational path from btn_level to any output.
- Minimum press width is 1 cycle: a 1-cycle high on btn_level produces press_pulse, then release_pulse on the following cycle.

## Configuration
- BTN_AUTO_REPEAT_EN
  - Defined: LONG-state repeat behaviour is exactly as above.
  - Undefined:
    - rep_cnt and its logic are not compiled.
    - repeat_pulse is tied to 0.
    - REPEAT_MS is ignored.
    - LONG holds with no strobes until fall.

## Test plan
All scenarios use CLK_FREQ=1000, LONG_MS=10, REPEAT_MS=4, which gives LONG_CYC=10 and REPEAT_CYC=4.
- Short press: btn_level high for 5 cycles.
  - press_pulse 1 cycle after the rise.
  - release_pulse 1 cycle after the fall.
  - No long_pulse.
  - held high for 5 cycles.
- Long hold: btn_level high for 25 cycles, with BTN_AUTO_REPEAT_EN defined.
  - long_pulse 10 cycles after press_pulse.
  - repeat_pulse at +4, +8, +12 after long_pulse, i.e. 3 pulses.
  - release_pulse after the fall.
  - long_held high from long_pulse until release.
- Boundary: btn_level falls on the exact edge where hold_cnt==9.
  - release_pulse only.
  - No long_pulse.
- Held through reset: btn_level=1 while reset is asserted for 3 cycles, then stays high for 20 cycles, then goes low.
  - No strobes at any point.
  - held stays 0.
- Reset mid-hold: reset is asserted 6 cycles after press_pulse while the button is still held.
  - All outputs go to 0 the next cycle.
  - No release_pulse.
  - A later re-press produces a normal press_pulse.
- Without BTN_AUTO_REPEAT_EN, hold for 25 cycles.
  - long_pulse at +10.
  - repeat_pulse stays 0 throughout.
